// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave decoding the byte register protocol onto a register-file port.
// Optional `SPI_MISO_TRISTATE_EN: miso floats while the synchronised select is high.
module spi_reg_bridge #(
  parameter int REG_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mosi,
  output logic              miso,
  input  logic              sclk,
  input  logic              nss,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_vld,
  input  logic [7:0]        status,
  output logic [5:0]        fastcmd,
  output logic              fastcmd_vld
);

  localparam int BYTES = REG_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_READ, ST_WRITE, ST_FAST, ST_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic sclk_m, sclk_s, sclk_q;
  logic mosi_m, mosi_s;
  logic nss_m, nss_s, nss_q;
  logic rise, fall, nss_fall;

  logic [2:0]       bit_cnt;
  logic [BC_W-1:0]  byte_cnt;
  logic [6:0]       rx_sh;
  logic [7:0]       rx_byte;
  logic [7:0]       tx_sh;
  logic [REG_W-1:0] rd_buf;
  logic             cap_pend;

  assign rise     = sclk_s & ~sclk_q;
  assign fall     = ~sclk_s & sclk_q;
  assign nss_fall = ~nss_s & nss_q;
  assign rx_byte  = {rx_sh, mosi_s};

`ifdef SPI_MISO_TRISTATE_EN
  assign miso = nss_s ? 1'bz : tx_sh[7];
`else
  assign miso = nss_s ? 1'b0 : tx_sh[7];
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (nss_s) begin
      state_d = ST_IDLE;
    end else if (nss_fall) begin
      state_d = ST_CMD;
    end else if (state_q == ST_CMD && rise && bit_cnt == 3'd7) begin
      case (rx_byte[7:6])
        2'b00:   state_d = ST_READ;
        2'b01:   state_d = ST_IGNORE;
        2'b10:   state_d = ST_WRITE;
        default: state_d = ST_FAST;
      endcase
    end
  end

  // The nss chain resets to "selected" so a select held low across reset
  // never looks like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_m         <= 1'b0;
      sclk_s         <= 1'b0;
      sclk_q         <= 1'b0;
      mosi_m         <= 1'b0;
      mosi_s         <= 1'b0;
      nss_m          <= 1'b0;
      nss_s          <= 1'b0;
      nss_q          <= 1'b0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      rx_sh          <= '0;
      tx_sh          <= '0;
      rd_buf         <= '0;
      cap_pend       <= 1'b0;
      reg_addr       <= '0;
      reg_data_o     <= '0;
      reg_data_o_vld <= 1'b0;
      fastcmd        <= '0;
      fastcmd_vld    <= 1'b0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_q <= sclk_s;
      mosi_m <= mosi;
      mosi_s <= mosi_m;
      nss_m  <= nss;
      nss_s  <= nss_m;
      nss_q  <= nss_s;

      reg_data_o_vld <= 1'b0;
      fastcmd_vld    <= 1'b0;
      cap_pend       <= 1'b0;
      if (cap_pend) rd_buf <= reg_data_i;
      if (reg_data_o_vld) reg_addr <= reg_addr + ADDR_W'(1);

      if (nss_s) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        rx_sh    <= '0;
        tx_sh    <= '0;
      end else if (nss_fall) begin
        tx_sh    <= status;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (state_q != ST_IDLE) begin
        if (rise) begin
          rx_sh   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state_q)
              ST_CMD: begin
                if (rx_byte[7:6] == 2'b11) begin
                  fastcmd     <= rx_byte[5:0];
                  fastcmd_vld <= 1'b1;
                end else if (!rx_byte[6]) begin
                  reg_addr <= rx_byte[ADDR_W-1:0];
                  cap_pend <= ~rx_byte[7];
                end
              end
              ST_WRITE: begin
                reg_data_o[{byte_cnt, 3'b000} +: 8] <= rx_byte;
                if (byte_cnt == LAST_BYTE) begin
                  byte_cnt       <= '0;
                  reg_data_o_vld <= 1'b1;
                end else begin
                  byte_cnt <= byte_cnt + BC_W'(1);
                end
              end
              default: ;
            endcase
          end
        end else if (fall) begin
          // bit_cnt wrapped to 0 means a byte just completed: load the next one.
          if (bit_cnt != 3'd0) begin
            tx_sh <= {tx_sh[6:0], 1'b0};
          end else if (state_q == ST_READ) begin
            tx_sh <= rd_buf[{byte_cnt, 3'b000} +: 8];
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              reg_addr <= reg_addr + ADDR_W'(1);
              cap_pend <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end else begin
            tx_sh <= 8'h00;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge (REG_W=16, ADDR_W=3): SPI master driver, frame-level
// reference model, strobe monitor and a final tally.
module tb_spi_reg_bridge;

  localparam int HALF = 8;

  logic        clk;
  logic        rst;
  logic        mosi;
  logic        miso;
  logic        sclk;
  logic        nss;
  logic [2:0]  reg_addr;
  logic [15:0] reg_data_i;
  logic [15:0] reg_data_o;
  logic        reg_data_o_vld;
  logic [7:0]  status;
  logic [5:0]  fastcmd;
  logic        fastcmd_vld;

  logic [15:0] mem [8];
  assign reg_data_i = mem[reg_addr];

  spi_reg_bridge #(.REG_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .mosi(mosi), .miso(miso), .sclk(sclk), .nss(nss),
    .reg_addr(reg_addr), .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
    .reg_data_o_vld(reg_data_o_vld), .status(status), .fastcmd(fastcmd),
    .fastcmd_vld(fastcmd_vld)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int fc_cnt = 0;
  logic [5:0]  last_fc = '0;
  logic [2:0]  last_addr = '0;
  logic [2:0]  addr_hist[$];
  logic [7:0]  mosi_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_miso_q[$];
  logic [18:0] exp_wr_q[$];
  logic [5:0]  exp_fc_q[$];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Frame-level model: what one complete frame must produce.
  function automatic void build_model();
    logic [7:0] cmd;
    int n;
    n = mosi_q.size();
    cmd = mosi_q[0];
    exp_miso_q.delete();
    exp_miso_q.push_back(status);
    for (int k = 1; k < n; k++) begin
      int w;
      logic [15:0] word;
      w = (k - 1) / 2;
      word = mem[(int'(cmd) + w) % 8];
      if (cmd < 8'h40) exp_miso_q.push_back(((k - 1) % 2 == 1) ? word[15:8] : word[7:0]);
      else             exp_miso_q.push_back(8'h00);
    end
    if (cmd >= 8'h80 && cmd < 8'hC0)
      for (int w = 0; 2 * w + 2 < n; w++)
        exp_wr_q.push_back({3'((int'(cmd) + w) % 8), mosi_q[2 * w + 2], mosi_q[2 * w + 1]});
    if (cmd >= 8'hC0) exp_fc_q.push_back(cmd[5:0]);
  endfunction

  // monitor: every strobe is checked against the expected queues
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_data_o_vld || fastcmd_vld)
        check("strobe_overlap", 32'(reg_data_o_vld & fastcmd_vld), 32'd0);
      if (reg_data_o_vld) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) begin
          check("unexpected_write", {13'd0, reg_addr, reg_data_o}, 32'h7FFFF);
        end else begin
          logic [18:0] e;
          e = exp_wr_q.pop_front();
          check("wr_addr", 32'(reg_addr), 32'(e[18:16]));
          check("wr_data", 32'(reg_data_o), 32'(e[15:0]));
        end
      end
      if (fastcmd_vld) begin
        fc_cnt++;
        last_fc = fastcmd;
        if (exp_fc_q.size() == 0) check("unexpected_fastcmd", 32'(fastcmd), 32'hFF);
        else                      check("fastcmd", 32'(fastcmd), 32'(exp_fc_q.pop_front()));
      end
      if (reg_addr != last_addr) addr_hist.push_back(reg_addr);
      last_addr = reg_addr;
    end
  end

  // driver tasks
  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      r[i] = miso;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic drive_frame();
    logic [7:0] r;
    got_q.delete();
    @(negedge clk);
    nss = 1'b0;
    repeat (HALF) @(negedge clk);
    foreach (mosi_q[i]) begin
      spi_byte(mosi_q[i], r);
      got_q.push_back(r);
    end
    repeat (HALF) @(negedge clk);
    nss = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < exp_miso_q.size(); i++)
      check($sformatf("miso_byte%0d", i), 32'(got_q[i]), 32'(exp_miso_q[i]));
`ifndef SPI_MISO_TRISTATE_EN
    check("miso_deselected", 32'(miso), 32'd0);
`endif
    check("missing_writes", exp_wr_q.size(), 0);
    check("missing_fastcmds", exp_fc_q.size(), 0);
    exp_wr_q.delete();
    exp_fc_q.delete();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_miso"}, 32'(miso), 32'd0);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_reg_data_o"}, 32'(reg_data_o), 32'd0);
    check({tag, "_wr_vld"}, 32'(reg_data_o_vld), 32'd0);
    check({tag, "_fastcmd"}, 32'(fastcmd), 32'd0);
    check({tag, "_fc_vld"}, 32'(fastcmd_vld), 32'd0);
  endtask

  initial begin
    int w0, f0;
    logic [7:0] r;
    rst = 1'b1; nss = 1'b1; sclk = 1'b0; mosi = 1'b0; status = 8'h00;
    foreach (mem[i]) mem[i] = 16'h0000;
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // status query
    status = 8'hA5;
    mosi_q = '{8'h00};
    w0 = wr_cnt; f0 = fc_cnt;
    build_model();
    drive_frame();
    check("sq_status", 32'(got_q[0]), 32'hA5);
    check("sq_no_strobes", (wr_cnt - w0) + (fc_cnt - f0), 0);

    // write burst
    status = 8'($urandom);
    mosi_q = '{8'h82, 8'h34, 8'h12, 8'h78, 8'h56};
    w0 = wr_cnt;
    build_model();
    check("wb_model0", 32'(exp_wr_q[0]), 32'({3'd2, 16'h1234}));
    check("wb_model1", 32'(exp_wr_q[1]), 32'({3'd3, 16'h5678}));
    drive_frame();
    check("wb_count", wr_cnt - w0, 2);

    // read with address wrap
    mem[7] = 16'hBEEF; mem[0] = 16'h00C3; status = 8'h3C;
    mosi_q = '{8'h07, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    addr_hist.delete();
    build_model();
    drive_frame();
    check("rd_status", 32'(got_q[0]), 32'h3C);
    check("rd_b1", 32'(got_q[1]), 32'hEF);
    check("rd_b2", 32'(got_q[2]), 32'hBE);
    check("rd_b3", 32'(got_q[3]), 32'hC3);
    check("rd_b4", 32'(got_q[4]), 32'h00);
    check("rd_addr_first", 32'(addr_hist.size() > 0 ? addr_hist[0] : 3'd5), 32'd7);
    check("rd_addr_wrap", 32'(addr_hist.size() > 1 ? addr_hist[1] : 3'd5), 32'd0);

    // fast command
    mosi_q = '{8'hC5, 8'h80};
    w0 = wr_cnt; f0 = fc_cnt;
    build_model();
    drive_frame();
    check("fc_count", fc_cnt - f0, 1);
    check("fc_code", 32'(last_fc), 32'd5);
    check("fc_miso_zero", 32'(got_q[1]), 32'h00);
    check("fc_no_write", wr_cnt - w0, 0);

    // aborted write: one data byte then deselect
    mosi_q = '{8'h81, 8'h11};
    w0 = wr_cnt;
    build_model();
    drive_frame();
    check("abort_no_write", wr_cnt - w0, 0);

    // reset in the middle of a read
    status = 8'h5A; mem[3] = 16'($urandom);
    @(negedge clk); nss = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_byte(8'h03, r);
    check("rstmid_status", 32'(r), 32'h5A);
    repeat (4) @(negedge clk);
    check("rstmid_addr", 32'(reg_addr), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rstmid");
    @(negedge clk);
    rst = 1'b0;
    f0 = fc_cnt;
    spi_byte(8'hC7, r);
    check("rstmid_idle_miso", 32'(r), 32'h00);
    check("rstmid_idle_no_fc", fc_cnt - f0, 0);
    repeat (HALF) @(negedge clk);
    nss = 1'b1;
    repeat (8) @(negedge clk);
    mosi_q = '{8'h86, 8'hCD, 8'hAB};
    w0 = wr_cnt;
    build_model();
    check("post_rst_model", 32'(exp_wr_q[0]), 32'({3'd6, 16'hABCD}));
    drive_frame();
    check("post_rst_write", wr_cnt - w0, 1);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int n;
      foreach (mem[i]) mem[i] = 16'($urandom);
      status = 8'($urandom);
      n = $urandom_range(1, 6);
      mosi_q.delete();
      for (int k = 0; k < n; k++) mosi_q.push_back(8'($urandom_range(0, 255)));
      build_model();
      drive_frame();
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
